// File: rtl/lii_tx_mux_if.sv
// Bundle of producer-side AXI-Stream lanes and the LII phy output channel for lii_tx_mux.
// The mux attaches through the slave modport; the producer/phy side uses master.
interface lii_tx_mux_if #(
    parameter int NIN = 2,
    parameter int PW  = 128
);
    logic [NIN*PW-1:0] s_tdata;
    logic [NIN-1:0]    s_tvalid;
    logic [NIN-1:0]    s_tready;
    logic [PW-1:0]     lii_out_tdata;
    logic              lii_out_tvalid;
    logic              lii_out_tready;
    logic [7:0]        lii_out_src;
    logic [7:0]        lii_out_dst;
    logic [NIN-1:0]    grant;

    modport master (
        output s_tdata, s_tvalid, lii_out_tready,
        input  s_tready, lii_out_tdata, lii_out_tvalid, lii_out_src, lii_out_dst, grant
    );

    modport slave (
        input  s_tdata, s_tvalid, lii_out_tready,
        output s_tready, lii_out_tdata, lii_out_tvalid, lii_out_src, lii_out_dst, grant
    );
endinterface

// File: rtl/lii_tx_mux.sv
// Round-robin burst arbiter merging NIN AXI-Stream producers onto one LII phy channel.
// Output is registered through a 2-entry skid buffer so phy ready never reaches s_tready combinationally.
module lii_tx_mux #(
    parameter int               NIN     = 2,
    parameter int               PW      = 128,
    parameter logic [7:0]       SRC_ID  = 8'h00,
    parameter logic [NIN*8-1:0] DST_IDS = {8'h01, 8'h00},
    parameter int               BURST   = 16
) (
    input logic          aclk,
    input logic          arstn,
    lii_tx_mux_if.slave  lii
);

    localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]     state;
    logic [NIN-1:0] grant_q;
    logic [IW-1:0]  last_q;
    logic [CW-1:0]  cnt_q;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [NIN-1:0] pick_oh;

    logic           cur_valid;
    logic [PW-1:0]  cur_data;
    logic [7:0]     cur_dst;

    logic           skid_not_full;
    logic [1:0]     occ;
    logic [1:0]     occ_next;
    logic [PW-1:0]  data0, data1;
    logic [7:0]     dst0, dst1;

    logic           accept;
    logic           pop;

    // Scan from last+1 modulo NIN and take the first stream with valid high.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        for (int k = 1; k <= NIN; k++) begin
            for (int i = 0; i < NIN; i++) begin
                if (!pick_found && lii.s_tvalid[i] && (i == (int'(last_q) + k) % NIN)) begin
                    pick_found = 1'b1;
                    pick_idx   = IW'(i);
                    pick_oh[i] = 1'b1;
                end
            end
        end
    end

    // last_q holds the granted index for the whole SEND phase.
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        cur_dst   = '0;
        for (int i = 0; i < NIN; i++) begin
            if (last_q == IW'(i)) begin
                cur_valid = lii.s_tvalid[i];
                cur_data  = lii.s_tdata[i*PW +: PW];
                cur_dst   = DST_IDS[i*8 +: 8];
            end
        end
    end

    assign accept = (state == S_SEND) && cur_valid && skid_not_full;
    assign pop    = (occ != 2'd0) && lii.lii_out_tready;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state   <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NIN - 1);
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state   <= S_SEND;
                        grant_q <= pick_oh;
                        last_q  <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if ((accept && (cnt_q == CW'(BURST - 1))) || !cur_valid) begin
                        state   <= S_IDLE;
                        grant_q <= '0;
                    end else if (accept) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        occ_next = occ;
        if (accept && !pop) begin
            occ_next = occ + 2'd1;
        end else if (!accept && pop) begin
            occ_next = occ - 2'd1;
        end
    end

    // Entry 0 is always the head; entry 1 only fills while the head is stalled.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            occ           <= 2'd0;
            skid_not_full <= 1'b1;
            data0         <= '0;
            data1         <= '0;
            dst0          <= '0;
            dst1          <= '0;
        end else begin
            occ           <= occ_next;
            skid_not_full <= (occ_next <= 2'd1);
            if (accept && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                data0 <= cur_data;
                dst0  <= cur_dst;
            end else if (pop) begin
                data0 <= data1;
                dst0  <= dst1;
            end
            if (accept && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
                data1 <= cur_data;
                dst1  <= cur_dst;
            end
        end
    end

    assign lii.s_tready       = grant_q & {NIN{skid_not_full}};
    assign lii.grant          = grant_q;
    assign lii.lii_out_tvalid = (occ != 2'd0);
    assign lii.lii_out_tdata  = data0;
    assign lii.lii_out_dst    = dst0;
    assign lii.lii_out_src    = SRC_ID;

endmodule

// File: tb/tb_lii_tx_mux.sv
// Scoreboard bench for lii_tx_mux: a two-stream BURST=4 instance and a single-stream BURST=1 instance.
// Issued beats go into per-stream expected queues; the monitor pops them as the phy side accepts output.
module tb_lii_tx_mux;

    localparam int         PW    = 128;
    localparam logic [7:0] SRC_A = 8'hA5;
    localparam logic [7:0] SRC_B = 8'h3C;
    localparam logic [7:0] DST_B = 8'h42;

    logic aclk  = 1'b0;
    logic arstn = 1'b0;

    always #5 aclk = ~aclk;

    lii_tx_mux_if #(.NIN(2), .PW(PW)) ifa ();
    lii_tx_mux_if #(.NIN(1), .PW(PW)) ifb ();

    lii_tx_mux #(
        .NIN(2), .PW(PW), .SRC_ID(SRC_A), .DST_IDS(16'h0100), .BURST(4)
    ) dut_a (
        .aclk  (aclk),
        .arstn (arstn),
        .lii   (ifa.slave)
    );

    lii_tx_mux #(
        .NIN(1), .PW(PW), .SRC_ID(SRC_B), .DST_IDS(DST_B), .BURST(1)
    ) dut_b (
        .aclk  (aclk),
        .arstn (arstn),
        .lii   (ifb.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [PW-1:0] src_q[3][$];
    logic [PW-1:0] exp_q[3][$];
    logic [7:0]    log_a[$];
    logic [7:0]    log_b[$];
    logic [7:0]    exp_pat[$];
    bit            log_en     = 1'b0;
    bit            rnd_mode   = 1'b0;
    logic          ready_a_fix = 1'b1;
    int            occ_a = 0;
    int            occ_a_prev = 0;
    int            occ_b = 0;

    function automatic void check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic queue_beats(int s, int n, int base);
        logic [PW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = PW'(s * 65536 + base + k);
            src_q[s].push_back(d);
            exp_q[s].push_back(d);
        end
    endtask

    task automatic push_pat(logic [7:0] v, int n);
        for (int k = 0; k < n; k++) exp_pat.push_back(v);
    endtask

    task automatic wait_drain(string name);
        int cyc;
        cyc = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() +
                exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 ||
                ifa.lii_out_tvalid || ifb.lii_out_tvalid) && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
        end
        check({name, "_drain_done"}, PW'(cyc < 3000), PW'(1));
        repeat (3) @(negedge aclk);
    endtask

    task automatic wait_grant(string name, logic [1:0] exp);
        int cyc;
        cyc = 0;
        while (ifa.grant == 2'b00 && cyc < 100) begin
            @(negedge aclk);
            cyc++;
        end
        check(name, PW'(ifa.grant), PW'(exp));
    endtask

    task automatic check_pattern(string name, bit sel);
        logic [7:0] work[$];
        int bad;
        if (sel) work = log_b;
        else     work = log_a;
        while (work.size() > 0 && work[0] == 8'hFF) void'(work.pop_front());
        bad = -1;
        for (int i = 0; i < exp_pat.size(); i++) begin
            if (i >= work.size() || work[i] !== exp_pat[i]) begin
                bad = i;
                break;
            end
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("[TB] FAIL %s: entry %0d got %0h expected %0h", name, bad,
                     (bad < work.size()) ? work[bad] : 8'hEE, exp_pat[bad]);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_a_tvalid"}, PW'(ifa.lii_out_tvalid), PW'(0));
        check({tag, "_a_tdata"},  ifa.lii_out_tdata,       PW'(0));
        check({tag, "_a_dst"},    PW'(ifa.lii_out_dst),    PW'(0));
        check({tag, "_a_src"},    PW'(ifa.lii_out_src),    PW'(SRC_A));
        check({tag, "_a_grant"},  PW'(ifa.grant),          PW'(0));
        check({tag, "_a_tready"}, PW'(ifa.s_tready),       PW'(0));
        check({tag, "_b_tvalid"}, PW'(ifb.lii_out_tvalid), PW'(0));
        check({tag, "_b_src"},    PW'(ifb.lii_out_src),    PW'(SRC_B));
    endtask

    // Sole driver of DUT inputs other than reset; changes them 1 time unit after each rising edge.
    initial begin : producer
        bit fire[3];
        ifa.s_tvalid       = '0;
        ifa.s_tdata        = '0;
        ifa.lii_out_tready = 1'b1;
        ifb.s_tvalid       = '0;
        ifb.s_tdata        = '0;
        ifb.lii_out_tready = 1'b1;
        forever begin
            @(negedge aclk);
            fire[0] = arstn && ifa.s_tvalid[0] && ifa.s_tready[0];
            fire[1] = arstn && ifa.s_tvalid[1] && ifa.s_tready[1];
            fire[2] = arstn && ifb.s_tvalid[0] && ifb.s_tready[0];
            @(posedge aclk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            ifa.s_tvalid[0]        = (src_q[0].size() > 0);
            ifa.s_tdata[0 +: PW]   = (src_q[0].size() > 0) ? src_q[0][0] : '0;
            ifa.s_tvalid[1]        = (src_q[1].size() > 0);
            ifa.s_tdata[PW +: PW]  = (src_q[1].size() > 0) ? src_q[1][0] : '0;
            ifb.s_tvalid[0]        = (src_q[2].size() > 0);
            ifb.s_tdata            = (src_q[2].size() > 0) ? src_q[2][0] : '0;
            ifa.lii_out_tready     = rnd_mode ? ($urandom_range(0, 1) == 1) : ready_a_fix;
        end
    end

    initial begin : monitor
        logic          stall_a;
        logic [PW-1:0] pd;
        logic [7:0]    pdst;
        int            ins;
        int            outs;
        int            sid;
        stall_a = 1'b0;
        pd      = '0;
        pdst    = '0;
        forever begin
            @(negedge aclk);
            if (!arstn) begin
                occ_a      = 0;
                occ_a_prev = 0;
                occ_b      = 0;
                stall_a    = 1'b0;
                continue;
            end
            if (stall_a) begin
                check("hold_valid", PW'(ifa.lii_out_tvalid), PW'(1));
                check("hold_data",  ifa.lii_out_tdata,       pd);
                check("hold_dst",   PW'(ifa.lii_out_dst),    PW'(pdst));
            end
            check("a_valid_latency", PW'(ifa.lii_out_tvalid), PW'(occ_a != 0));
            if (occ_a == 2 && occ_a_prev == 2) check("a_tready_when_full", PW'(ifa.s_tready), PW'(0));
            ins  = $countones(ifa.s_tvalid & ifa.s_tready);
            outs = 0;
            if (ifa.lii_out_tvalid && ifa.lii_out_tready) begin
                outs = 1;
                check("a_src", PW'(ifa.lii_out_src), PW'(SRC_A));
                sid = (ifa.lii_out_dst == 8'h00) ? 0 : (ifa.lii_out_dst == 8'h01) ? 1 : -1;
                if (sid < 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL a_dst: got %0h expected 0 or 1", ifa.lii_out_dst);
                end else if (exp_q[sid].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL a_extra_beat: got %0h expected none on stream %0d", ifa.lii_out_tdata, sid);
                end else begin
                    check("a_data", ifa.lii_out_tdata, exp_q[sid].pop_front());
                end
                if (log_en) log_a.push_back(ifa.lii_out_dst);
            end else if (log_en) begin
                log_a.push_back(8'hFF);
            end
            occ_a_prev = occ_a;
            occ_a      = occ_a + ins - outs;
            if (ins > 0) check("a_occupancy_bound", PW'(occ_a <= 2), PW'(1));
            stall_a = ifa.lii_out_tvalid && !ifa.lii_out_tready;
            pd      = ifa.lii_out_tdata;
            pdst    = ifa.lii_out_dst;

            check("b_valid_latency", PW'(ifb.lii_out_tvalid), PW'(occ_b != 0));
            ins  = $countones(ifb.s_tvalid & ifb.s_tready);
            outs = 0;
            if (ifb.lii_out_tvalid && ifb.lii_out_tready) begin
                outs = 1;
                check("b_src", PW'(ifb.lii_out_src), PW'(SRC_B));
                check("b_dst", PW'(ifb.lii_out_dst), PW'(DST_B));
                if (exp_q[2].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL b_extra_beat: got %0h expected none", ifb.lii_out_tdata);
                end else begin
                    check("b_data", ifb.lii_out_tdata, exp_q[2].pop_front());
                end
                if (log_en) log_b.push_back(ifb.lii_out_dst);
            end else if (log_en) begin
                log_b.push_back(8'hFF);
            end
            occ_b = occ_b + ins - outs;
        end
    end

    initial begin : main
        int         cyc;
        int         c0;
        int         c1;
        int         start;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        @(posedge aclk);
        #3 arstn = 1'b1;

        // Single stream: bursts of 4,4,2 with a bubble between them.
        @(negedge aclk);
        log_a.delete();
        log_en = 1'b1;
        queue_beats(0, 10, 0);
        wait_drain("t1");
        exp_pat.delete();
        push_pat(8'h00, 4); push_pat(8'hFF, 1);
        push_pat(8'h00, 4); push_pat(8'hFF, 1);
        push_pat(8'h00, 2);
        check_pattern("t1_bursts", 1'b0);

        // Both streams saturated; stream 0 went last so stream 1 leads.
        log_a.delete();
        queue_beats(0, 24, 100);
        queue_beats(1, 24, 100);
        wait_drain("t2");
        exp_pat.delete();
        for (int r = 0; r < 4; r++) begin
            push_pat(8'h01, 4); push_pat(8'hFF, 1);
            push_pat(8'h00, 4); push_pat(8'hFF, 1);
        end
        check_pattern("t2_alternation", 1'b0);
        start = 0;
        while (start < log_a.size() && log_a[start] == 8'hFF) start++;
        c0 = 0;
        c1 = 0;
        for (int i = start; i < start + 40 && i < log_a.size(); i++) begin
            if (log_a[i] == 8'h00) c0++;
            if (log_a[i] == 8'h01) c1++;
        end
        check("t2_beats_stream0", PW'(c0), PW'(16));
        check("t2_beats_stream1", PW'(c1), PW'(16));

        // Stream 1 alone, then idle-gap release.
        log_a.delete();
        queue_beats(1, 3, 200);
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (!(ifa.grant == 2'b10 && !ifa.s_tvalid[1]) && cyc < 100);
        check("t3_gap_seen", PW'(cyc < 100), PW'(1));
        @(negedge aclk);
        check("t3_grant_release", PW'(ifa.grant), PW'(0));
        wait_drain("t3");
        exp_pat.delete();
        push_pat(8'h01, 3);
        check_pattern("t3_three_beats", 1'b0);
        queue_beats(0, 2, 300);
        queue_beats(1, 2, 300);
        wait_grant("t3_rr_next_is_s0", 2'b01);
        wait_drain("t3b");

        // Random phy backpressure with both streams active.
        log_en   = 1'b0;
        rnd_mode = 1'b1;
        queue_beats(0, 30, 400);
        queue_beats(1, 30, 400);
        wait_drain("t4");
        rnd_mode    = 1'b0;
        ready_a_fix = 1'b1;
        repeat (2) @(negedge aclk);

        // Reset mid-burst with the skid buffer full.
        ready_a_fix = 1'b0;
        queue_beats(0, 6, 500);
        cyc = 0;
        while (occ_a != 2 && cyc < 100) begin
            @(negedge aclk);
            cyc++;
        end
        check("t5_buffer_full", PW'(occ_a), PW'(2));
        @(posedge aclk);
        #2 arstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        #1;
        check_reset_outputs("t5_midburst");
        repeat (2) @(posedge aclk);
        #3 arstn = 1'b1;
        ready_a_fix = 1'b1;
        @(negedge aclk);
        queue_beats(0, 2, 600);
        queue_beats(1, 2, 600);
        wait_grant("t5_first_after_reset", 2'b01);
        wait_drain("t5");

        // Single-stream instance with BURST=1: one idle cycle after every beat.
        log_b.delete();
        log_en = 1'b1;
        queue_beats(2, 6, 700);
        wait_drain("t6");
        exp_pat.delete();
        for (int k = 0; k < 5; k++) begin
            push_pat(DST_B, 1);
            push_pat(8'hFF, 1);
        end
        push_pat(DST_B, 1);
        check_pattern("t6_half_rate", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/lii_tx_mux.md
# lii_tx_mux

Transmit-side LII endpoint. Merges `NIN` logical AXI-Stream producers onto one LII phy output channel. Each beat is tagged with this node's `src` ID and the destination ID of the producer it came from. Producers are granted the channel in round-robin bursts of at most `BURST` beats. The output is fully registered through a 2-entry skid buffer, so no combinational path runs from `lii_out_tready` to any `s_tready`. It sits between HLS kernel output streams and the LII fabric, feeding the phy input port of a downstream kernel wrapper.

## Interface
- `NIN`, 2, number of logical input streams (1..8)
- `PW`, 128, packing/data width
- `SRC_ID`, 8'h00, value driven on `lii_out_src`
- `DST_IDS`, {8'h01,8'h00}, `NIN*8` bits; byte i is the destination for stream i
- `BURST`, 16, max beats per grant (>=1)
- `aclk` in 1: clock; single clock domain
- `arstn` in 1: asynchronous, active-low reset
- `s_tdata` in `NIN*PW`: stream i occupies bits [i*PW +: PW]
- `s_tvalid` in `NIN`: per-stream valid
- `s_tready` out `NIN`: per-stream ready
- `lii_out_tdata` out `PW`: phy data
- `lii_out_tvalid` out 1: phy valid
- `lii_out_tready` in 1: phy ready
- `lii_out_src` out 8: source ID
- `lii_out_dst` out 8: destination ID of the current beat
- `grant` out `NIN`: one-hot, the stream currently owning the channel; 0 in IDLE

## Operation
- FSM states: IDLE, SEND.
- IDLE:
  - If any `s_tvalid` is high, pick the first valid index scanning from `last+1` modulo `NIN`.
  - Register the pick into `grant` and `last`, clear the beat counter, and go to SEND.
  - No beat is accepted in IDLE.
- SEND:
  - `s_tready[g] = grant[g] & skid_not_full`. All other `s_tready` bits are 0.
  - Accepted beat (valid & ready) = {`s_tdata` slice, `DST_IDS` byte g}. It is pushed into the skid buffer and the counter is incremented.
- Leave SEND for IDLE when either condition holds:
  - a beat is accepted with counter == `BURST-1`, or
  - the granted stream's `s_tvalid` is low in a SEND cycle (idle-gap release).
- Skid buffer, 2 entries:
  - `lii_out_*` is driven from the head entry.
  - Pop on `lii_out_tvalid & lii_out_tready`.
  - `skid_not_full` is a register. It means at most 1 entry is occupied after the current cycle's push and pop.
  - Push and pop in the same cycle keeps the occupancy unchanged.
- `lii_out_src` is constant `SRC_ID` whenever valid. `lii_out_dst` is stored per entry, so beats from different streams in flight keep their own dst.
- `NIN=1`: the arbiter degenerates. Behaviour is otherwise identical, including the IDLE cycle between bursts.
- Beats are never dropped, duplicated or reordered within a stream.

## Timing
- Reset values (asynchronous on `arstn` low):
  - FSM = IDLE, `grant`=0, `last`=`NIN-1` (so stream 0 wins first), counter=0, skid empty.
  - `s_tready`=0, `lii_out_tvalid`=0, `lii_out_tdata`=0, `lii_out_dst`=0, `lii_out_src`=`SRC_ID`.
- Arbitration cost: 1 IDLE cycle per grant. The first beat can be accepted the cycle after a valid producer is seen in IDLE.
- Latency: a beat accepted at cycle t appears on `lii_out_tvalid` at t+1 when the skid buffer is empty.
- Throughput: 1 beat/cycle within a burst when `lii_out_tready` is held high. A full burst takes `BURST` beats in `BURST+1` cycles.
- Backpressure: the output holds data/valid/dst stable while `lii_out_tready`=0. `s_tready` drops no later than 1 cycle after the buffer reaches 2 entries.
- Reset asserted mid-burst: all in-flight skid contents are discarded, and outputs return to reset values immediately.
- A SEND exit by counter and a simultaneous `s_tvalid` drop count as one exit. The next IDLE arbitrates normally.

## Test plan
- Single stream, `NIN=2`, `BURST=4`, stream 0 sends 10 beats (data=k), tready=1 -> output shows bursts of 4,4,2 with one bubble between them, dst=8'h00, src=`SRC_ID`, data 0..9 in order.
- Both streams continuously valid, `BURST=4` -> output pattern is 4 beats dst 00, bubble, 4 beats dst 01, bubble, repeating. Beats per stream are equal over 40 cycles.
- Stream 1 only, 3 beats then tvalid low -> 3 beats with dst 01, then `grant`=0 within 1 cycle. A later stream-0 request is granted next.
- Random `lii_out_tready` (50%) with both streams active -> scoreboard shows no loss, duplication or reordering per stream. Output is stable while stalled, and `s_tready`=0 within 1 cycle of the buffer filling.
- `arstn` pulsed low mid-burst with 2 beats buffered -> next cycle all outputs are at reset values. After release, stream 0 is granted first.
- `NIN=1`, `BURST=1` -> every beat is followed by 1 idle cycle, so throughput is 1/2. Data is intact.
